circ_buf_reader: RTL and testbench

- Read-side controller for the parallel circular Buffer.
- The writer deposits K words per push. This block tracks occupancy, drives the Buffer read address, and captures J-word chunks from par_out into an output register.
- It presents each chunk downstream on a valid/ready handshake and back-pressures the writer through wr_ready.
- It sits between Buffer.par_out and the downstream consumer (e.g. the PE array feed).

---
 rtl/buf_pkg.sv | 26 ++
 rtl/circ_buf_reader_occ_counter.sv | 58 +++++
 rtl/circ_buf_reader.sv | 95 +++++++++
 tb/tb_circ_buf_reader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/buf_pkg.sv
// Shared constants and types for the parallel circular Buffer and its
// reader/writer controllers.
package buf_pkg;

  localparam int DEF_SIZE  = 16;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_K     = 4;
  localparam int DEF_J     = 8;

  localparam int BUF_AW = $clog2(DEF_SIZE);
  localparam int BUF_CW = $clog2(DEF_SIZE) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } rd_state_e;

  function automatic int aw_of(input int size);
    return $clog2(size);
  endfunction

  function automatic int cw_of(input int size);
    return $clog2(size) + 1;
  endfunction

endpackage

// File: rtl/circ_buf_reader_occ_counter.sv
// Occupancy counter: up by INC on an accepted request, down by DEC,
// with a space-available flag and a sticky overflow flag.
module occ_counter #(
  parameter int SIZE = 16,
  parameter int INC  = 4,
  parameter int DEC  = 8,
  parameter int CW   = $clog2(SIZE) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          inc_req,
  input  logic          dec,
  output logic          space_ok,
  output logic          have_dec,
  output logic [CW-1:0] count,
  output logic          overflow
);

  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] space;
  logic          push;

  assign space    = CW'(SIZE) - count_q;
  assign space_ok = space >= CW'(INC);
  assign have_dec = count_q >= CW'(DEC);
  assign push     = inc_req & space_ok;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      // both terms apply when a push and a pop share a cycle
      count_d = count_q
              + (push ? CW'(INC) : '0)
              - (dec  ? CW'(DEC) : '0);
      ovf_d   = ovf_q | (inc_req & ~space_ok);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/circ_buf_reader.sv
// Read-side controller for the parallel circular Buffer: tracks occupancy,
// steps the read pointer and hands J-word chunks downstream.
module circ_buf_reader
  import buf_pkg::*;
#(
  parameter int SIZE  = DEF_SIZE,
  parameter int WIDTH = DEF_WIDTH,
  parameter int K     = DEF_K,
  parameter int J     = DEF_J,
  parameter int AW    = $clog2(SIZE),
  parameter int CW    = $clog2(SIZE) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               wr_done,
  output logic               wr_ready,
  output logic [AW-1:0]      read_add,
  input  logic [WIDTH*J-1:0] buf_data,
  output logic [WIDTH*J-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CW-1:0]      count,
  output logic               overflow
);

  rd_state_e          state_q, state_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH*J-1:0] data_q, data_d;
  logic               capture;
  logic               have_chunk;

  occ_counter #(
    .SIZE (SIZE),
    .INC  (K),
    .DEC  (J),
    .CW   (CW)
  ) u_occ (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .inc_req  (wr_done),
    .dec      (capture),
    .space_ok (wr_ready),
    .have_dec (have_chunk),
    .count    (count),
    .overflow (overflow)
  );

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    data_d   = data_q;
    capture  = 1'b0;
    if (flush) begin
      state_d  = IDLE;
      rd_ptr_d = '0;
      data_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: capture = have_chunk;
        HOLD: begin
          if (out_ready) begin
            capture = have_chunk;
            if (!have_chunk) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      // pointer wraps through AW-bit truncation
      if (capture) begin
        data_d   = buf_data;
        rd_ptr_d = rd_ptr_q + AW'(J);
        state_d  = HOLD;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      data_q   <= data_d;
    end
  end

  assign read_add  = rd_ptr_q;
  assign out_data  = data_q;
  assign out_valid = (state_q == HOLD);

endmodule

// File: tb/tb_circ_buf_reader.sv
// Directed bench for circ_buf_reader with a small Buffer/writer model
// that stores incrementing word values.
module tb_circ_buf_reader;

  localparam int SIZE  = 16;
  localparam int WIDTH = 8;
  localparam int K     = 4;
  localparam int J     = 8;
  localparam int AW    = 4;
  localparam int CW    = 5;

  logic               clk;
  logic               rst;
  logic               flush;
  logic               wr_done;
  logic               wr_ready;
  logic [AW-1:0]      read_add;
  logic [WIDTH*J-1:0] buf_data;
  logic [WIDTH*J-1:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic [CW-1:0]      count;
  logic               overflow;

  int total = 0;
  int bad   = 0;

  circ_buf_reader #(
    .SIZE  (SIZE),
    .WIDTH (WIDTH),
    .K     (K),
    .J     (J),
    .AW    (AW),
    .CW    (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .wr_done   (wr_done),
    .wr_ready  (wr_ready),
    .read_add  (read_add),
    .buf_data  (buf_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer + writer model: each accepted push writes K incrementing values
  logic [WIDTH-1:0] mem [SIZE];
  logic [AW-1:0]    wp;
  logic [WIDTH-1:0] val;

  initial begin
    for (int i = 0; i < SIZE; i++) mem[i] = '0;
  end

  always @(posedge clk) begin
    if (rst || flush) begin
      wp  <= '0;
      val <= '0;
    end else if (wr_done && wr_ready) begin
      for (int i = 0; i < K; i++)
        mem[4'(wp + 4'(i))] <= 8'(val + 8'(i));
      wp  <= 4'(wp + 4'(K));
      val <= 8'(val + 8'(K));
    end
  end

  always_comb begin
    buf_data = '0;
    for (int i = 0; i < J; i++)
      buf_data[WIDTH*i +: WIDTH] = mem[4'(read_add + 4'(i))];
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    wr_done   = 1'b0;
    out_ready = 1'b0;

    // 1. async reset mid-cycle
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_read_add", 64'(read_add), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_wr_ready", 64'(wr_ready), 64'd1);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    tick();
    tick();
    rst = 1'b0;

    // 2. basic chunk
    out_ready = 1'b1;
    wr_done   = 1'b1;
    tick();
    tick();
    wr_done = 1'b0;
    chk("b_count8", 64'(count), 64'd8);
    chk("b_valid0", 64'(out_valid), 64'd0);
    tick();
    chk("b_valid1", 64'(out_valid), 64'd1);
    chk("b_data", out_data, 64'h0706050403020100);
    chk("b_read_add", 64'(read_add), 64'd8);
    chk("b_count0", 64'(count), 64'd0);
    tick();
    chk("b_valid_drop", 64'(out_valid), 64'd0);

    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("f0_read_add", 64'(read_add), 64'd0);
    chk("f0_count", 64'(count), 64'd0);

    // 3. backpressure / full
    out_ready = 1'b0;
    wr_done   = 1'b1;
    repeat (4) tick();
    chk("bp_valid", 64'(out_valid), 64'd1);
    chk("bp_data", out_data, 64'h0706050403020100);
    chk("bp_count8", 64'(count), 64'd8);
    chk("bp_wr_ready1", 64'(wr_ready), 64'd1);
    chk("bp_read_add", 64'(read_add), 64'd8);
    repeat (2) tick();
    chk("full_count", 64'(count), 64'd16);
    chk("full_wr_ready0", 64'(wr_ready), 64'd0);
    chk("full_ovf0", 64'(overflow), 64'd0);
    tick();
    wr_done = 1'b0;
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_count", 64'(count), 64'd16);
    chk("ovf_data_held", out_data, 64'h0706050403020100);

    // 4. wrap
    out_ready = 1'b1;
    tick();
    chk("w1_data", out_data, 64'h0f0e0d0c0b0a0908);
    chk("w1_read_add", 64'(read_add), 64'd0);
    chk("w1_count", 64'(count), 64'd8);
    tick();
    chk("w2_data", out_data, 64'h1716151413121110);
    chk("w2_read_add", 64'(read_add), 64'd8);
    chk("w2_count", 64'(count), 64'd0);
    chk("w2_wr_ready", 64'(wr_ready), 64'd1);
    chk("w2_ovf_sticky", 64'(overflow), 64'd1);

    // 5. simultaneous push and capture
    out_ready = 1'b0;
    wr_done   = 1'b1;
    tick();
    tick();
    chk("s_count8", 64'(count), 64'd8);
    chk("s_hold_data", out_data, 64'h1716151413121110);
    out_ready = 1'b1;
    tick();
    chk("s_count4", 64'(count), 64'd4);
    chk("s_valid", 64'(out_valid), 64'd1);
    chk("s_data", out_data, 64'h1f1e1d1c1b1a1918);
    chk("s_read_add", 64'(read_add), 64'd0);

    // 6. flush (with a push requested on the same cycle)
    out_ready = 1'b0;
    tick();
    tick();
    chk("pf_count12", 64'(count), 64'd12);
    chk("pf_valid", 64'(out_valid), 64'd1);
    chk("pf_ovf", 64'(overflow), 64'd1);
    flush = 1'b1;
    tick();
    flush   = 1'b0;
    wr_done = 1'b0;
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_read_add", 64'(read_add), 64'd0);
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_ovf", 64'(overflow), 64'd0);
    chk("fl_wr_ready", 64'(wr_ready), 64'd1);
    out_ready = 1'b1;
    wr_done   = 1'b1;
    tick();
    wr_done = 1'b0;
    chk("a_count4", 64'(count), 64'd4);
    chk("a_valid0", 64'(out_valid), 64'd0);
    tick();
    chk("a_idle_valid0", 64'(out_valid), 64'd0);
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    chk("a_count8", 64'(count), 64'd8);
    chk("a_valid0b", 64'(out_valid), 64'd0);
    tick();
    chk("a_valid1", 64'(out_valid), 64'd1);
    chk("a_data", out_data, 64'h0706050403020100);
    chk("a_read_add", 64'(read_add), 64'd8);
    chk("a_count0", 64'(count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
